// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa division, round-to-nearest-even,
// flush-to-zero on subnormals, valid/ready handshake and IEEE status flags.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         div_by_zero,
  output logic         inexact,
  output logic         busy
);
  localparam int CNT_W = $clog2(MAN_W + 4);
  localparam logic [EXP_W+1:0] BIAS  = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W+1:0] E_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);
  localparam logic [W-1:0]     QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLASSIFY, DIV, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]     a_r, b_r;
  logic [EXP_W+1:0] e_r;
  logic [MAN_W+1:0] rem_r;
  logic [MAN_W:0]   d_r;
  logic [MAN_W+2:0] q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       flags_r;

  logic             sa, sb, sgn;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [W-1:0]     inf_v, zero_v, spec_res, rnd_res;
  logic [4:0]       spec_fl, rnd_fl;

  logic [MAN_W+2:0] qn;
  logic [EXP_W+1:0] e_adj, e_fin;
  logic [MAN_W+1:0] sum;
  logic [MAN_W-1:0] mant_f;
  logic             g, r, sticky, inc, ovf, unf;
  logic             geq;
  logic [MAN_W:0]   diff;

  assign {sa, ea, ma} = a_r;
  assign {sb, eb, mb} = b_r;
  assign sgn    = sa ^ sb;
  assign inf_v  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_v = {sgn, {(W-1){1'b0}}};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign {overflow, underflow, invalid, div_by_zero, inexact} = flags_r;

  // Subnormals (exp == 0) are treated as zero.
  always_comb begin
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == '1) && (ma == '0);
    b_inf    = (eb == '1) && (mb == '0);
    a_nan    = (ea == '1) && (ma != '0);
    b_nan    = (eb == '1) && (mb != '0);
    special  = 1'b1;
    spec_res = '0;
    spec_fl  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_fl  = 5'b00100;
    end else if (a_inf) begin
      spec_res = inf_v;
    end else if (b_zero) begin
      spec_res = inf_v;
      spec_fl  = 5'b00010;
    end else if (a_zero || b_inf) begin
      spec_res = zero_v;
    end else begin
      special = 1'b0;
    end
  end

  assign geq  = (rem_r >= {1'b0, d_r});
  assign diff = rem_r[MAN_W:0] - d_r;

  // After a left normalise the round bit is zero; the next quotient bit lives in rem, so sticky covers it.
  always_comb begin
    qn    = q_r;
    e_adj = e_r;
    if (!q_r[MAN_W+2]) begin
      qn    = {q_r[MAN_W+1:0], 1'b0};
      e_adj = e_r - E_ONE;
    end
    g      = qn[1];
    r      = qn[0];
    sticky = |rem_r;
    inc    = g & (r | sticky | qn[2]);
    sum    = {1'b0, qn[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, inc};
    mant_f = sum[MAN_W-1:0];
    e_fin  = e_adj;
    if (sum[MAN_W+1]) begin
      mant_f = sum[MAN_W:1];
      e_fin  = e_adj + E_ONE;
    end
    ovf = !e_fin[EXP_W+1] && (e_fin >= E_MAX);
    unf = e_fin[EXP_W+1] || (e_fin == '0);
    rnd_res = {sgn, e_fin[EXP_W-1:0], mant_f};
    rnd_fl  = {4'b0000, g | r | sticky};
    if (ovf) begin
      rnd_res = inf_v;
      rnd_fl  = 5'b10001;
    end else if (unf) begin
      rnd_res = zero_v;
      rnd_fl  = 5'b01001;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (in_valid) state_nx = CLASSIFY;
      CLASSIFY: state_nx = special ? DONE : DIV;
      DIV:      if (cnt_r == CNT_W'(1)) state_nx = ROUND;
      ROUND:    state_nx = DONE;
      DONE:     if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      a_r     <= '0;
      b_r     <= '0;
      e_r     <= '0;
      rem_r   <= '0;
      d_r     <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      result  <= '0;
      flags_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            flags_r <= '0;
          end
        end
        CLASSIFY: begin
          if (special) begin
            result  <= spec_res;
            flags_r <= spec_fl;
          end else begin
            rem_r <= {2'b01, ma};
            d_r   <= {1'b1, mb};
            e_r   <= {2'b00, ea} - {2'b00, eb} + BIAS;
            q_r   <= '0;
            cnt_r <= CNT_W'(MAN_W + 3);
          end
        end
        DIV: begin
          if (geq) begin
            rem_r <= {diff, 1'b0};
            q_r   <= {q_r[MAN_W+1:0], 1'b1};
          end else begin
            rem_r <= {rem_r[MAN_W:0], 1'b0};
            q_r   <= {q_r[MAN_W+1:0], 1'b0};
          end
          cnt_r <= cnt_r - CNT_W'(1);
        end
        ROUND: begin
          result  <= rnd_res;
          flags_r <= rnd_fl;
        end
        default: ;
      endcase
    end
  end
endmodule
